// File: rtl/sha_pad_sequencer.sv
`timescale 1ns/1ps
// SHA-256 message padder: packs a byte stream into 512-bit blocks with 0x80, zero fill and 64-bit bit length.
// Latency: block valid 1 cycle after the byte that completes it; a spill block follows back-to-back.
// Backpressure: in_ready drops while a block is presented; block outputs hold until blk_ready.
module sha_pad_sequencer #(
  parameter int BYTE_PTR_W = 6,
  parameter int LEN_W      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [511:0]     blk_data,
  output logic             blk_first,
  output logic             blk_last,
  output logic             busy,
  output logic [LEN_W-1:0] msg_bits
);

  localparam int BLK_BYTES = 1 << BYTE_PTR_W;
  localparam logic [BYTE_PTR_W:0] LEN_POS = (BYTE_PTR_W+1)'(BLK_BYTES - 8);
  localparam logic [BYTE_PTR_W:0] FULL    = (BYTE_PTR_W+1)'(BLK_BYTES);

  typedef enum logic {FILL, EMIT} state_t;
  typedef enum logic [1:0] {P_NONE, P_80, P_LEN} pend_t;

  state_t                state, state_n;
  pend_t                 pend, pend_n;
  logic [BYTE_PTR_W-1:0] ptr, ptr_n;
  logic [511:0]          blk_buf, buf_n;
  logic [LEN_W-1:0]      bits_n;
  logic                  first_flag, first_n;
  logic                  last_flag, last_n;

  logic                  in_fire;
  logic                  out_fire;
  logic [BYTE_PTR_W:0]   q;
  logic [BYTE_PTR_W+2:0] wr_off;
  logic [BYTE_PTR_W+2:0] pad_off;

  assign in_ready  = (state == FILL) & ~rst;
  assign blk_valid = (state == EMIT);
  assign blk_data  = blk_buf;
  assign blk_first = (state == EMIT) & first_flag;
  assign blk_last  = last_flag;
  assign busy      = (state == EMIT) | (msg_bits != '0);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = blk_valid & blk_ready;
  assign q        = {1'b0, ptr} + (BYTE_PTR_W+1)'(1);
  // Byte i lives at bit offset (63-i)*8, i.e. the inverted index shifted by 3.
  assign wr_off   = {~ptr, 3'b000};
  assign pad_off  = {~q[BYTE_PTR_W-1:0], 3'b000};

  // Next-state, block assembly and pending spill-block bookkeeping.
  always_comb begin
    state_n = state;
    pend_n  = pend;
    ptr_n   = ptr;
    buf_n   = blk_buf;
    bits_n  = msg_bits;
    first_n = first_flag;
    last_n  = last_flag;
    case (state)
      FILL: begin
        if (in_fire) begin
          bits_n = msg_bits + LEN_W'(8);
          buf_n[wr_off +: 8] = in_data;
          if (!in_last) begin
            if (q == FULL) begin
              state_n = EMIT;
              last_n  = 1'b0;
              ptr_n   = '0;
            end else begin
              ptr_n = q[BYTE_PTR_W-1:0];
            end
          end else begin
            state_n = EMIT;
            ptr_n   = '0;
            if (q < LEN_POS + (BYTE_PTR_W+1)'(0) || q == LEN_POS - (BYTE_PTR_W+1)'(0) && 1'b0) begin
              buf_n[pad_off +: 8]  = 8'h80;
              buf_n[LEN_W-1:0]     = bits_n;
              last_n               = 1'b1;
            end else if (q < FULL) begin
              buf_n[pad_off +: 8] = 8'h80;
              last_n              = 1'b0;
              pend_n              = P_LEN;
            end else begin
              last_n = 1'b0;
              pend_n = P_80;
            end
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          first_n = 1'b0;
          if (pend != P_NONE) begin
            // Length-carrying block goes out immediately behind the current one.
            if (pend == P_80) begin
              buf_n = {8'h80, {(512-8-LEN_W){1'b0}}, msg_bits};
            end else begin
              buf_n = {{(512-LEN_W){1'b0}}, msg_bits};
            end
            pend_n = P_NONE;
            last_n = 1'b1;
          end else begin
            state_n = FILL;
            buf_n   = '0;
            if (last_flag) begin
              bits_n  = '0;
              first_n = 1'b1;
              last_n  = 1'b0;
            end
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  // State and datapath registers; reset discards any partial message or pending block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      pend       <= P_NONE;
      ptr        <= '0;
      blk_buf    <= '0;
      msg_bits   <= '0;
      first_flag <= 1'b1;
      last_flag  <= 1'b0;
    end else begin
      state      <= state_n;
      pend       <= pend_n;
      ptr        <= ptr_n;
      blk_buf    <= buf_n;
      msg_bits   <= bits_n;
      first_flag <= first_n;
      last_flag  <= last_n;
    end
  end

endmodule

// File: tb/tb_sha_pad_sequencer.sv
`timescale 1ns/1ps
module tb_sha_pad_sequencer;

  typedef logic [7:0] byte_t;
  typedef struct {
    logic [511:0] d;
    logic         f;
    logic         l;
    logic         nb;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         busy;
  logic [63:0]  msg_bits;

  int n_cmp = 0;
  int n_bad = 0;
  int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  exp_t expq[$];

  sha_pad_sequencer #(.BYTE_PTR_W(6), .LEN_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .busy(busy), .msg_bits(msg_bits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Reference model: FIPS 180-4 padding computed on the whole message, then split into blocks.
  task automatic push_model(input byte_t m[$]);
    byte_t p[$];
    logic [63:0] bits;
    int nb;
    exp_t e;
    bits = 64'(m.size()) * 64'd8;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 64;
    for (int i = 0; i < nb; i++) begin
      e.d = '0;
      for (int j = 0; j < 64; j++) e.d[511 - 8*j -: 8] = p[64*i + j];
      e.f  = (i == 0);
      e.l  = (i == nb - 1);
      // Final block holds no message bytes: it must follow the previous one without a gap.
      e.nb = (i == nb - 2) && (m.size() <= (nb - 1) * 64);
      expq.push_back(e);
    end
  endtask

  task automatic send(input byte_t m[$], input bit gaps);
    int t;
    for (int i = 0; i < m.size(); i++) begin
      in_valid = 1'b1;
      in_data  = m[i];
      in_last  = (i == m.size() - 1);
      t = 0;
      while (!in_ready && t < 3000) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 3000) begin
        timeout_fail("in_ready_wait");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);   // in_last without in_valid must be ignored
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_last = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((expq.size() != 0 || busy) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 5000) timeout_fail(name);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_blk_valid"}, 512'(blk_valid), 512'(0));
    chk({tag, "_blk_data"},  blk_data, 512'(0));
    chk({tag, "_blk_first"}, 512'(blk_first), 512'(0));
    chk({tag, "_blk_last"},  512'(blk_last), 512'(0));
    chk({tag, "_busy"},      512'(busy), 512'(0));
    chk({tag, "_msg_bits"},  512'(msg_bits), 512'(0));
    chk({tag, "_in_ready"},  512'(in_ready), 512'(0));
  endtask

  function automatic void mk_seq(output byte_t m[$], input int n, input int start, input int step);
    m = {};
    for (int i = 0; i < n; i++) m.push_back(8'(start + i * step));
  endfunction

  // blk_ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       blk_ready = 1'b0;
        1:       blk_ready = 1'b1;
        default: blk_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every block handshake; checks hold-while-stalled and no-bubble spill.
  initial begin
    exp_t e;
    bit stall = 0;
    bit nb_pend = 0;
    logic [511:0] hold_d = '0;
    logic hold_f = 1'b0;
    logic hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
        nb_pend = 0;
      end else begin
        if (nb_pend) begin
          chk("no_bubble_valid", 512'(blk_valid), 512'(1));
          nb_pend = 0;
        end
        if (stall) begin
          chk("hold_valid", 512'(blk_valid), 512'(1));
          chk("hold_data", blk_data, hold_d);
          chk("hold_flags", 512'({blk_first, blk_last}), 512'({hold_f, hold_l}));
          chk("stall_in_ready", 512'(in_ready), 512'(0));
        end
        if (blk_valid && blk_ready) begin
          if (expq.size() == 0) begin
            timeout_fail("unexpected_block");
          end else begin
            e = expq.pop_front();
            chk("blk_data", blk_data, e.d);
            chk("blk_first_last", 512'({blk_first, blk_last}), 512'({e.f, e.l}));
            nb_pend = e.nb;
          end
          stall = 0;
        end else begin
          stall = blk_valid;
        end
        hold_d = blk_data;
        hold_f = blk_first;
        hold_l = blk_last;
      end
    end
  end

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_t m[$];
    byte_t abc[$];
    int len;
    abc = {8'h61, 8'h62, 8'h63};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 512'(in_ready), 512'(1));
    @(posedge clk); #1;

    // "abc": one block, valid 1 cycle after the final byte
    ready_mode = 1;
    push_model(abc);
    send(abc, 0);
    chk("abc_latency", 512'(blk_valid), 512'(1));
    drain("abc_drain");

    // 55, 56 and 64-byte boundaries
    mk_seq(m, 55, 0, 1);
    push_model(m); send(m, 0); drain("len55");
    mk_seq(m, 56, 0, 1);
    push_model(m); send(m, 0); drain("len56");
    mk_seq(m, 64, 8'hAA, 0);
    push_model(m); send(m, 0); drain("len64");

    // Backpressure for 10 cycles, then a fresh "abc"
    ready_mode = 0;
    @(posedge clk); #1;
    push_model(abc);
    send(abc, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_valid", 512'(blk_valid), 512'(1));
    chk("bp_in_ready", 512'(in_ready), 512'(0));
    ready_mode = 1;
    drain("bp_drain");
    push_model(abc); send(abc, 0); drain("abc2_drain");

    // Reset after 20 bytes discards the partial message
    mk_seq(m, 20, 8'h10, 3);
    send(m, 0);
    chk("partial_msg_bits", 512'(msg_bits), 512'(160));
    chk("partial_busy", 512'(busy), 512'(1));
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_model(abc); send(abc, 0);
    chk("abc3_latency", 512'(blk_valid), 512'(1));
    drain("abc3_drain");

    // Randomized messages with random gaps and random blk_ready
    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0:       len = 55 + $urandom_range(0, 9);
        1:       len = 119 + $urandom_range(0, 9);
        default: len = $urandom_range(1, 200);
      endcase
      m = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      push_model(m);
      send(m, 1);
    end
    drain("random_drain");
    chk("final_queue_empty", 512'(expq.size()), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
